// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding for the add/sub select and
// the default datapath width.
package alu_pkg;

    localparam logic        ALU_OP_ADD = 1'b0;
    localparam logic        ALU_OP_SUB = 1'b1;
    localparam int unsigned ALU_WIDTH  = 32;

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry slice built from full_adder cells.
module adder_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    // Each bit keeps its own carry net so the chain is not one self-dependent vector.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic cin;
        logic cout;
        if (i == 0) begin : g_first
            assign cin = ci;
        end else begin : g_next
            assign cin = g_bit[i-1].cout;
        end
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (cin),
            .s  (s[i]),
            .co (cout)
        );
    end

    assign co = g_bit[W-1].cout;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple chains.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one S-bit slice per stage, global stall.
// Define PIPELINED_ADDER_FLAGS_EN to add registered zero/neg result flags.
module pipelined_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             overflow
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int unsigned S = WIDTH / STAGES;
    localparam int unsigned L = STAGES - 1;

    logic             v_q   [STAGES];
    logic             v_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_q   [STAGES];
    logic             c_d   [STAGES];
    logic             ovf_q;
    logic             ovf_d;
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic             zero_q;
    logic             zero_d;
    logic             neg_q;
    logic             neg_d;
`endif

    logic             advance;
    logic [WIDTH-1:0] b_in;
    logic             v_src  [STAGES];
    logic [WIDTH-1:0] a_src  [STAGES];
    logic [WIDTH-1:0] b_src  [STAGES];
    logic [WIDTH-1:0] s_src  [STAGES];
    logic             ci_src [STAGES];
    logic [S-1:0]     sl_sum [STAGES];
    logic             sl_co  [STAGES];

    assign b_in = (sub == ALU_OP_SUB) ? ~b : b;

    // Stage k sees either the fresh operands (k = 0) or what stage k-1 registered.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_entry
            assign v_src[k]  = in_valid;
            assign a_src[k]  = a;
            assign b_src[k]  = b_in;
            assign s_src[k]  = '0;
            assign ci_src[k] = (sub == ALU_OP_SUB);
        end else begin : g_chain
            assign v_src[k]  = v_q[k-1];
            assign a_src[k]  = a_q[k-1];
            assign b_src[k]  = b_q[k-1];
            assign s_src[k]  = s_q[k-1];
            assign ci_src[k] = c_q[k-1];
        end

        adder_slice #(
            .W (S)
        ) u_slice (
            .a  (a_src[k][k*S +: S]),
            .b  (b_src[k][k*S +: S]),
            .ci (ci_src[k]),
            .s  (sl_sum[k]),
            .co (sl_co[k])
        );
    end

    always_comb begin
        advance = !v_q[L] || out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            v_d[k]            = v_src[k];
            a_d[k]            = a_src[k];
            b_d[k]            = b_src[k];
            s_d[k]            = s_src[k];
            s_d[k][k*S +: S]  = sl_sum[k];
            c_d[k]            = sl_co[k];
        end
        ovf_d = (a_src[L][WIDTH-1] == b_src[L][WIDTH-1]) &&
                (s_d[L][WIDTH-1] != a_src[L][WIDTH-1]);
`ifdef PIPELINED_ADDER_FLAGS_EN
        zero_d = (s_d[L] == '0);
        neg_d  = s_d[L][WIDTH-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
`ifdef PIPELINED_ADDER_FLAGS_EN
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
`endif
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            ovf_q <= ovf_d;
`ifdef PIPELINED_ADDER_FLAGS_EN
            zero_q <= zero_d;
            neg_q  <= neg_d;
`endif
        end
    end

    assign in_ready  = advance;
    assign out_valid = v_q[L];
    assign sum       = s_q[L];
    assign co        = c_q[L];
    assign overflow  = ovf_q;
`ifdef PIPELINED_ADDER_FLAGS_EN
    assign zero      = zero_q;
    assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4) with an
// arithmetic reference model and an in-order scoreboard.
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              co;
    logic              overflow;
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic              zero;
    logic              neg;
`endif

    int                checks = 0;
    int                errors = 0;
    logic [33:0]       exp_q[$];
    logic              acc;
    logic              got_out;
    logic              prev_stall = 1'b0;
    logic [31:0]       prev_sum;
    logic              prev_co;
    logic              prev_ovf;
    logic [31:0]       last_sum;
    logic              last_co;
    logic              last_ovf;
    int                n_out = 0;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .overflow  (overflow)
`ifdef PIPELINED_ADDER_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg)
`endif
    );

    always #5 clk = ~clk;

    // Reference: signed result range decides overflow, unsigned compare/sum decides carry.
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint          sx;
        longint          sy;
        longint          r;
        longint unsigned ux;
        longint unsigned uy;
        logic            c;
        logic            v;
        logic [31:0]     res;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        if (s) begin
            r   = sx - sy;
            c   = (ux >= uy);
            res = x - y;
        end else begin
            r   = sx + sy;
            c   = ((ux + uy) >> 32) != 0;
            res = x + y;
        end
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {v, c, res};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cycle(input logic vin, input logic [31:0] ai, input logic [31:0] bi,
                             input logic si, input logic ordy);
        logic [33:0] e;
        @(negedge clk);
        in_valid  = vin;
        a         = ai;
        b         = bi;
        sub       = si;
        out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, prev_sum);
            chk("hold_co", co, prev_co);
            chk("hold_ovf", overflow, prev_ovf);
        end
        chk("in_ready", in_ready, !out_valid || ordy);
        got_out = 1'b0;
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e[31:0]);
                chk("co", co, e[32]);
                chk("overflow", overflow, e[33]);
`ifdef PIPELINED_ADDER_FLAGS_EN
                chk("zero", zero, e[31:0] == 32'd0);
                chk("neg", neg, e[31]);
`endif
                last_sum = sum;
                last_co  = co;
                last_ovf = overflow;
                got_out  = 1'b1;
                n_out++;
            end
        end
        acc = vin && in_ready;
        if (acc) exp_q.push_back(ref_op(ai, bi, si));
        prev_stall = out_valid && !ordy;
        prev_sum   = sum;
        prev_co    = co;
        prev_ovf   = overflow;
    endtask

    task automatic do_op(input string tag, input logic [31:0] ai, input logic [31:0] bi, input logic si,
                         input logic [31:0] esum, input logic eco, input logic eovf);
        int lat;
        run_cycle(1'b1, ai, bi, si, 1'b1);
        chk({tag, "_accept"}, acc, 1);
        lat = 0;
        while (!got_out && lat < 20) begin
            run_cycle(1'b0, '0, '0, 1'b0, 1'b1);
            lat++;
        end
        chk({tag, "_latency"}, lat, STAGES);
        chk({tag, "_sum"}, last_sum, esum);
        chk({tag, "_co"}, last_co, eco);
        chk({tag, "_ovf"}, last_ovf, eovf);
    endtask

    initial begin
        int c;
        int sent;
        int k;
        int base;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_co", co, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        do_op("add_basic", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        do_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op("sub_neg",   32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        // Backpressure: 8 back-to-back ops, downstream stalls on cycles 5..7.
        c = 0; sent = 0; k = 0;
        while (c < 60 && !(sent == 8 && exp_q.size() == 0)) begin
            run_cycle(sent < 8, sent, sent, 1'b0, !(c >= 5 && c <= 7));
            if (c >= 5 && c <= 7) chk("bp_in_ready_low", in_ready, 0);
            if (acc) sent++;
            if (got_out) begin
                chk("bp_order", last_sum, 2 * k);
                k++;
            end
            c++;
        end
        chk("bp_timeout", c < 60, 1);
        chk("bp_count", k, 8);

        // Reset with three ops in flight, the oldest already presented.
        run_cycle(1'b1, 32'd10, 32'd1, 1'b0, 1'b1);
        run_cycle(1'b1, 32'd20, 32'd2, 1'b0, 1'b1);
        run_cycle(1'b1, 32'd30, 32'd3, 1'b0, 1'b1);
        run_cycle(1'b0, '0, '0, 1'b0, 1'b1);
        run_cycle(1'b0, '0, '0, 1'b0, 1'b0);
        chk("mid_valid_before", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_co", co, 0);
        exp_q.delete();
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, '0, '0, 1'b0, 1'b1);
            chk("no_stale", out_valid, 0);
        end
        do_op("post_rst", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

        // Randomised traffic with corner operands mixed in.
        base = n_out; sent = 0; c = 0;
        while (sent < 10000 && c < 60000) begin
            case ($urandom_range(0, 7))
                0: ra = 32'h0000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'h0000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0000;
                3: rb = 32'h0000_0001;
                default: rb = $urandom;
            endcase
            run_cycle($urandom_range(0, 9) < 7, ra, rb, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 9) < 7);
            if (acc) sent++;
            c++;
        end
        chk("rand_sent", sent, 10000);
        c = 0;
        while (exp_q.size() != 0 && c < 50) begin
            run_cycle(1'b0, '0, '0, 1'b0, 1'b1);
            c++;
        end
        chk("rand_drain", exp_q.size(), 0);
        chk("rand_count", n_out - base, 10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
